// File: rtl/conv1d_window_pkg.sv
// conv1d_window_pkg: shared counter type and small counter helpers for the
// 1-D convolution window builder.
//
// `WIDTH_DATA normally comes from the shared define.v; the guarded fallback
// below only applies when that file has not been compiled ahead of this one.
// Optional feature macro used by this block: CONV1D_WIN_ZERO_PAD_EN.

`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

package conv1d_window_pkg;

  // Counters are as wide as the K/S parameters so any legal K fits.
  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  // Fill count after one more shift, saturating at the kernel size.
  function automatic cnt_t fill_inc(input cnt_t fill, input cnt_t k);
    return (fill >= k) ? k : fill + cnt_t'(1);
  endfunction

  // Stride phase after one more shift, wrapping at the stride.
  function automatic cnt_t phase_inc(input cnt_t ph, input cnt_t s);
    return ((ph + cnt_t'(1)) >= s) ? '0 : ph + cnt_t'(1);
  endfunction

endpackage

// File: rtl/conv1d_win_shreg.sv
// conv1d_win_shreg: K-deep sample shift register with a flattened parallel
// view. Slot 0 (LSBs) holds the oldest sample, slot K-1 (MSBs) the newest.
// A shift moves every sample down one slot and loads slot K-1 with either
// the incoming sample or zero (zero_ins), which the padding flush uses.

module conv1d_win_shreg #(
  parameter int unsigned K = 15,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift_en,
  input  logic           zero_ins,
  input  logic [W-1:0]   din,
  output logic [K*W-1:0] win
);

  logic [W-1:0] slot_in;

  // Select what enters the newest slot: real sample or a padding zero.
  always_comb begin
    slot_in = zero_ins ? '0 : din;
  end

  // Shift the window down by one slot on each enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '0;
    end else if (shift_en) begin
      win <= {slot_in, win[K*W-1:W]};
    end
  end

endmodule

// File: rtl/conv1d_window.sv
// conv1d_window: turns a framed sample stream into K-sample windows for a
// downstream conv1d, emitting one window every S shifts once the window is
// full, plus a forced tail window (out_last) on the final shift of a frame.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; the source holds valid and payload stable until that edge, and ready
// never depends on the source's valid.
//
// Optional feature macro: CONV1D_WIN_ZERO_PAD_EN ("same" padding, P=(K-1)/2
// zeros before and after every frame, with a FLUSH state for the trailing
// zeros). Without it the FLUSH state and padding logic are not built.

`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module conv1d_window
  import conv1d_window_pkg::*;
#(
  parameter logic [15:0] K = 16'd15,
  parameter logic [15:0] S = 16'd1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [`WIDTH_DATA-1:0]    in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [K*`WIDTH_DATA-1:0]  out_data,
  output logic                      out_last,
  output logic                      frame_err
);

  localparam int unsigned KI = 32'(K);
  localparam int unsigned W  = `WIDTH_DATA;

  cnt_t fill;
  cnt_t phase;
  cnt_t fill_after;
  cnt_t phase_after;

  logic out_free;     // output register is empty or being taken this cycle
  logic accept;       // input beat transfers this cycle
  logic shift;        // window shifts this cycle (sample or padding zero)
  logic zero_ins;     // the shift inserts a zero instead of in_data
  logic final_shift;  // this shift is the last one of the frame
  logic full_after;   // window holds K frame samples after this shift
  logic emit;         // load a new window into the output register

  assign out_free = !out_valid || out_ready;

`ifdef CONV1D_WIN_ZERO_PAD_EN
  localparam cnt_t P          = (K - 16'd1) >> 1;
  localparam cnt_t FILL_START = P;

  localparam logic ST_RUN_ENC   = 1'b0;
  localparam logic ST_FLUSH_ENC = 1'b1;

  typedef enum logic {
    ST_RUN   = ST_RUN_ENC,
    ST_FLUSH = ST_FLUSH_ENC
  } state_t;

  state_t state;
  cnt_t   flush_cnt;
  logic   flush_shift;

  // Input is blocked while trailing zeros are pushed; a flush shift takes
  // the same slot an input beat would have taken.
  always_comb begin
    in_ready    = out_free && (state == ST_RUN);
    accept      = in_valid && in_ready;
    flush_shift = (state == ST_FLUSH) && out_free;
    shift       = accept || flush_shift;
    zero_ins    = flush_shift;
    final_shift = flush_shift && (flush_cnt == P - cnt_t'(1));
  end

  // RUN -> FLUSH on the accepted last sample, back to RUN after P zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept && in_last) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          if (flush_shift) begin
            flush_cnt <= flush_cnt + cnt_t'(1);
            if (final_shift) begin
              state <= ST_RUN;
            end
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end
`else
  localparam cnt_t FILL_START = '0;

  // Without padding the accepted in_last beat is the final shift.
  always_comb begin
    in_ready    = out_free;
    accept      = in_valid && in_ready;
    shift       = accept;
    zero_ins    = 1'b0;
    final_shift = accept && in_last;
  end
`endif

  // Post-shift fill/phase and the emit decision, including the tail rule.
  always_comb begin
    fill_after  = fill_inc(fill, K);
    full_after  = (fill_after == K);
    // Phase stays 0 until the window first fills, so the first full
    // window always emits; afterwards it counts shifts modulo S.
    phase_after = (fill == K) ? phase_inc(phase, S) : '0;
    emit        = shift && full_after && ((phase_after == '0) || final_shift);
  end

  // Fill and phase counters; both restart after the final shift of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill  <= FILL_START;
      phase <= '0;
    end else if (shift) begin
      if (final_shift) begin
        fill  <= FILL_START;
        phase <= '0;
      end else begin
        fill  <= fill_after;
        phase <= phase_after;
      end
    end
  end

  // Output valid/last register and the short-frame error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= final_shift && !full_after;
      if (emit) begin
        out_valid <= 1'b1;
        out_last  <= final_shift;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // The shift register itself is the output data register: shifts only
  // happen while the output is free, so a pending window never moves.
  conv1d_win_shreg #(
    .K (KI),
    .W (W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift),
    .zero_ins (zero_ins),
    .din      (in_data),
    .win      (out_data)
  );

endmodule

// File: tb/tb_conv1d_window.sv
// tb_conv1d_window: directed and randomized frames for conv1d_window with
// K=3, S=2, checked against a frame-level reference model (padded sample
// list per frame, windows picked by position). Builds with or without
// CONV1D_WIN_ZERO_PAD_EN.

`timescale 1ns/1ps

`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module tb_conv1d_window;

  localparam logic [15:0] K = 16'd3;
  localparam logic [15:0] S = 16'd2;
  localparam int KI    = 3;
  localparam int SI    = 2;
  localparam int W     = `WIDTH_DATA;
  localparam int WIN_W = KI * W;
`ifdef CONV1D_WIN_ZERO_PAD_EN
  localparam int P = (KI - 1) / 2;
`else
  localparam int P = 0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIN_W-1:0] out_data;
  logic             out_last;
  logic             frame_err;

  conv1d_window #(
    .K (K),
    .S (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  // Scoreboard: expected {out_last, window} in emission order.
  logic [WIN_W:0] exp_q[$];
  // Reference model: the (padded) samples of the frame in progress.
  logic [W-1:0]   frm[$];

  int  n_checks   = 0;
  int  n_pass     = 0;
  int  exp_err    = 0;
  int  got_err    = 0;
  bit  rand_ready = 0;
  logic ready_force = 1'b1;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed time %0t, required finish before 500000", $time);
    $fatal(1, "bench did not complete");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Append one element of the padded frame; a window is due when the
  // window is full and its end position is a multiple of S past the first
  // full position, or unconditionally on the frame's final element.
  function automatic void model_push(input logic [W-1:0] v, input logic fin);
    int e;
    logic [WIN_W-1:0] w;
    w = '0;
    frm.push_back(v);
    e = frm.size() - 1;
    if (frm.size() >= KI) begin
      if (fin || ((e - (KI - 1)) % SI) == 0) begin
        for (int i = 0; i < KI; i++) w[i*W +: W] = frm[e - KI + 1 + i];
        exp_q.push_back({fin, w});
      end
    end else if (fin) begin
      exp_err++;
    end
    if (fin) frm.delete();
  endfunction

  // One accepted input sample: leading zeros at frame start, trailing
  // zeros after the last sample when padding is built in.
  function automatic void model_accept(input logic [W-1:0] v, input logic last);
    if (frm.size() == 0) begin
      for (int i = 0; i < P; i++) model_push('0, 1'b0);
    end
    model_push(v, last && (P == 0));
    if (last && (P > 0)) begin
      for (int i = 0; i < P; i++) model_push('0, i == P - 1);
    end
  endfunction

  // Output consumer and per-cycle monitor, sampled mid-cycle.
  initial begin : monitor
    logic             hold_prev;
    logic [WIN_W-1:0] held;
    logic [WIN_W:0]   got;
    hold_prev = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
`ifdef CONV1D_WIN_ZERO_PAD_EN
        check("in_ready_gate", 128'(in_ready && out_valid && !out_ready), 128'(0));
`else
        check("in_ready", 128'(in_ready), 128'(!out_valid || out_ready));
`endif
        if (hold_prev) begin
          check("hold_valid", 128'(out_valid), 128'(1));
          check("hold_data", 128'(out_data), 128'(held));
        end
        if (out_valid && out_ready) begin
          n_checks++;
          assert (exp_q.size() != 0) n_pass++;
          else $error("FAIL spurious_window: observed %0h expected no window", {out_last, out_data});
          if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check("window", 128'({out_last, out_data}), 128'(got));
          end
        end
        if (frame_err) got_err++;
        hold_prev = out_valid && !out_ready;
        held      = out_data;
      end
    end
  end

  // Downstream ready: fixed level or random back-pressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] v, input logic last);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", 128'(acc), 128'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = W'($urandom);
    if (acc) model_accept(v, last);
`ifdef CONV1D_WIN_ZERO_PAD_EN
    if (acc && last) begin
      @(negedge clk);
      check("flush_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
    end
`endif
  endtask

  task automatic send_seq(input int start, input int len);
    for (int i = 0; i < len; i++) send(W'(start + i), i == len - 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) idle(1);
    idle(3);
    check("drain", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    idle(2);
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_frame_err", 128'(frame_err), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    frm.delete();
    exp_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int len;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    idle(1);
    do_reset();

    // Frame 1..5 and frame 1..6 with a free-running consumer.
    send_seq(1, 5);
    drain();
    send_seq(1, 6);
    drain();

    // Short frame followed by a full one.
    send_seq(1, 2);
    send_seq(7, 3);
    drain();
    check("err_after_short", 128'(got_err), 128'(exp_err));

    // Back-pressure: fill until a window is pending, then stall a sample.
    ready_force = 1'b0;
    idle(1);
    for (int i = 0; i < KI - P; i++) send(W'(10 + i), 1'b0);
    in_valid = 1'b1;
    in_data  = W'(10 + KI - P);
    in_last  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready", 128'(in_ready), 128'(0));
      check("stall_out_valid", 128'(out_valid), 128'(1));
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    send(W'(10 + KI - P), 1'b0);
    send(W'(20), 1'b1);
    drain();

    // Reset in the middle of a frame, then a clean frame.
    send(W'(1), 1'b0);
    send(W'(2), 1'b0);
    drain();
    do_reset();
    send_seq(4, 3);
    drain();

    // Random frames under random back-pressure and input gaps.
    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        send(W'($urandom_range(1, (1 << W) - 1)), i == len - 1);
        idle($urandom_range(0, 2));
      end
    end
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    drain();

    check("frame_err_count", 128'(got_err), 128'(exp_err));
    check("leftover_samples", 128'(frm.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
